// File: rtl/sha256_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// sha256_round_ctrl_if
//   Groups the block handshake and the datapath strobes of the SHA-256 round
//   controller into one bundle.
//
//   Upstream / control inputs (driven by master):
//     blk_valid     512-bit block present, held stable until accepted
//     blk_first     block is the first of a message (sampled at acceptance)
//     blk_last      block is the last of a message (sampled at acceptance)
//     abort         synchronous abort of the current message
//   Controller outputs (driven by slave):
//     blk_ready     controller can accept a block
//     w_init        load block into the message-schedule register file
//     w_next        shift message schedule by one word
//     h_init        load SHA-256 initial hash values into H
//     ws_init       load working variables a..h from H
//     ws_update     perform one compression round
//     h_update      add working variables into H
//     round[5:0]    current round index t (K[t] lookup)
//     busy          block in progress
//     digest_valid  one-cycle pulse: H holds the final digest
// ---------------------------------------------------------------------------
interface sha256_round_ctrl_if;
    logic       blk_valid;
    logic       blk_first;
    logic       blk_last;
    logic       abort;
    logic       blk_ready;
    logic       w_init;
    logic       w_next;
    logic       h_init;
    logic       ws_init;
    logic       ws_update;
    logic       h_update;
    logic [5:0] round;
    logic       busy;
    logic       digest_valid;

    // Upstream source plus the datapath that consumes the strobes.
    modport master (
        output blk_valid, blk_first, blk_last, abort,
        input  blk_ready, w_init, w_next, h_init, ws_init, ws_update,
               h_update, round, busy, digest_valid
    );

    // The round controller itself.
    modport slave (
        input  blk_valid, blk_first, blk_last, abort,
        output blk_ready, w_init, w_next, h_init, ws_init, ws_update,
               h_update, round, busy, digest_valid
    );
endinterface

// File: rtl/sha256_round_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_round_ctrl
//   Sequencing FSM for one SHA-256 compression engine. For each accepted
//   block it issues: LOAD (w_init, h_init on the first block), PREP
//   (ws_init), ROUNDS cycles of ws_update/w_next with round = 0..ROUNDS-1,
//   FINAL (h_update) and, for the last block of a message, DONE
//   (digest_valid).
//
//   Parameters:
//     ROUNDS        compression rounds per block, 2..64
//   Ports:
//     clk           rising-edge clock
//     Reset         asynchronous active-low reset
//     bus           sha256_round_ctrl_if.slave (handshake + strobes)
//
//   Every output is a flop loaded from the next-state decode, so outputs
//   never glitch with inputs and all change together on the clock edge.
// ---------------------------------------------------------------------------
module sha256_round_ctrl #(
    parameter int ROUNDS = 64
) (
    input  logic               clk,
    input  logic               Reset,
    sha256_round_ctrl_if.slave bus
);

    if (ROUNDS < 2 || ROUNDS > 64) begin : g_bad_rounds
        $error("sha256_round_ctrl: ROUNDS must be in 2..64");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PREP,
        S_ROUNDS,
        S_FINAL,
        S_DONE
    } state_e;

    localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);

    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       first_q, first_d;
    logic       last_q, last_d;

    logic       blk_ready_q;
    logic       busy_q;
    logic       w_init_q;
    logic       h_init_q;
    logic       ws_init_q;
    logic       rnd_act_q;      // drives both ws_update and w_next
    logic       h_update_q;
    logic       digest_valid_q;
    logic [5:0] round_q;

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // case can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        last_d  = last_q;

        // Abort outranks every other transition, including ROUNDS end and
        // FINAL, but is meaningless in IDLE so it cannot block acceptance.
        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            first_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.blk_valid) begin
                        state_d = S_LOAD;
                        first_d = bus.blk_first;
                        last_d  = bus.blk_last;
                    end
                end
                S_LOAD:  state_d = S_PREP;
                S_PREP: begin
                    state_d = S_ROUNDS;
                    cnt_d   = '0;
                end
                S_ROUNDS: begin
                    if (cnt_q == LAST_RND) begin
                        state_d = S_FINAL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                // A non-last block skips DONE so the next block of the
                // message can be accepted one cycle earlier.
                S_FINAL: state_d = last_q ? S_DONE : S_IDLE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            first_q        <= 1'b0;
            last_q         <= 1'b0;
            blk_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            w_init_q       <= 1'b0;
            h_init_q       <= 1'b0;
            ws_init_q      <= 1'b0;
            rnd_act_q      <= 1'b0;
            h_update_q     <= 1'b0;
            digest_valid_q <= 1'b0;
            round_q        <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            first_q        <= first_d;
            last_q         <= last_d;
            blk_ready_q    <= (state_d == S_IDLE);
            busy_q         <= (state_d != S_IDLE);
            w_init_q       <= (state_d == S_LOAD);
            h_init_q       <= (state_d == S_LOAD) && first_d;
            ws_init_q      <= (state_d == S_PREP);
            rnd_act_q      <= (state_d == S_ROUNDS);
            h_update_q     <= (state_d == S_FINAL);
            digest_valid_q <= (state_d == S_DONE);
            round_q        <= (state_d == S_ROUNDS) ? cnt_d : 6'd0;
        end
    end

    assign bus.blk_ready    = blk_ready_q;
    assign bus.busy         = busy_q;
    assign bus.w_init       = w_init_q;
    assign bus.h_init       = h_init_q;
    assign bus.ws_init      = ws_init_q;
    assign bus.ws_update    = rnd_act_q;
    assign bus.w_next       = rnd_act_q;
    assign bus.h_update     = h_update_q;
    assign bus.digest_valid = digest_valid_q;
    assign bus.round        = round_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sha256_round_ctrl
//   Two controllers (ROUNDS=64 and ROUNDS=4) share one input stream. For
//   each instance a reference model tracks "cycles since acceptance" and
//   derives the expected output word from the block schedule; the expected
//   word is queued at the clock edge and a separate monitor pops and
//   compares it against the DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_sha256_round_ctrl;

    typedef struct packed {
        logic       blk_ready;
        logic       busy;
        logic       w_init;
        logic       h_init;
        logic       ws_init;
        logic       ws_update;
        logic       w_next;
        logic       h_update;
        logic       digest_valid;
        logic [5:0] round;
    } out_t;

    logic clk;
    logic Reset;
    logic blk_valid;
    logic blk_first;
    logic blk_last;
    logic abort;

    int checks   = 0;
    int failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected outputs for a cycle, from the block schedule: offset 1 is
    // LOAD, 2 is PREP, 3..r+2 are rounds 0..r-1, r+3 is FINAL, r+4 is DONE.
    function automatic out_t expect_out(bit act, int off, bit fst, int r);
        out_t o;
        o = '0;
        if (!act) begin
            o.blk_ready = 1'b1;
        end else begin
            o.busy = 1'b1;
            if (off == 1) begin
                o.w_init = 1'b1;
                o.h_init = fst;
            end else if (off == 2) begin
                o.ws_init = 1'b1;
            end else if (off <= r + 2) begin
                o.ws_update = 1'b1;
                o.w_next    = 1'b1;
                o.round     = 6'(off - 3);
            end else if (off == r + 3) begin
                o.h_update = 1'b1;
            end else begin
                o.digest_valid = 1'b1;
            end
        end
        return o;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int R = (g == 0) ? 64 : 4;

        sha256_round_ctrl_if bus ();

        assign bus.blk_valid = blk_valid;
        assign bus.blk_first = blk_first;
        assign bus.blk_last  = blk_last;
        assign bus.abort     = abort;

        sha256_round_ctrl #(.ROUNDS(R)) dut (
            .clk   (clk),
            .Reset (Reset),
            .bus   (bus.slave)
        );

        out_t act_o;
        assign act_o = {bus.blk_ready, bus.busy, bus.w_init, bus.h_init,
                        bus.ws_init, bus.ws_update, bus.w_next, bus.h_update,
                        bus.digest_valid, bus.round};

        out_t exp_q[$];
        int   exp_digests = 0;
        int   got_digests = 0;
        bit   m_act = 1'b0;
        int   m_off = 0;
        bit   m_fst = 1'b0;
        bit   m_lst = 1'b0;
        out_t e_w;

        // Reference model: advances at the rising edge on the sampled inputs.
        initial forever begin
            @(posedge clk);
            if (!Reset) begin
                m_act = 1'b0;
                exp_q.delete();
            end else begin
                if (m_act) begin
                    if (abort || m_off == (m_lst ? R + 4 : R + 3))
                        m_act = 1'b0;
                    else
                        m_off++;
                end else if (blk_valid) begin
                    m_act = 1'b1;
                    m_off = 1;
                    m_fst = blk_first;
                    m_lst = blk_last;
                end
                exp_q.push_back(expect_out(m_act, m_off, m_fst, R));
                if (m_act && m_off == R + 4) exp_digests++;
            end
        end

        // Monitor: compares the DUT against the queued expectation.
        initial forever begin
            @(negedge clk);
            if (!Reset) begin
                exp_q.delete();
            end else if (exp_q.size() > 0) begin
                e_w = exp_q.pop_front();
                check($sformatf("R%0d_outputs@%0t", R, $time),
                      {17'b0, act_o}, {17'b0, e_w});
                if (act_o.digest_valid) got_digests++;
            end
        end
    end

    // While Reset is low every output other than blk_ready must be 0.
    task automatic check_reset_outs(input string tag);
        out_t a;
        a = g_dut[0].act_o;
        a.blk_ready = 1'b0;
        check({tag, "_R64"}, {17'b0, a}, 32'd0);
        a = g_dut[1].act_o;
        a.blk_ready = 1'b0;
        check({tag, "_R4"}, {17'b0, a}, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic f, input logic l,
                         input logic ab);
        blk_valid = v;
        blk_first = f;
        blk_last  = l;
        abort     = ab;
    endtask

    task automatic idle_for(input int n);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (n) step();
    endtask

    initial begin
        Reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("power_on_reset");
        @(posedge clk);
        #3;
        Reset = 1'b1;
        repeat (3) step();

        // Single-block message.
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        step();
        idle_for(75);

        // Two-block message, second block held valid from the next cycle.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (70) step();
        idle_for(80);

        // Abort around round 30, then abort with a simultaneous block in
        // IDLE, which must still be accepted.
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (32) step();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        step();
        idle_for(80);

        // Reset pulse around round 10, then a fresh block.
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (13) step();
        #2;
        Reset = 1'b0;
        #1;
        check_reset_outs("async_reset_mid_block");
        step();
        @(posedge clk);
        #3;
        Reset = 1'b1;
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        step();
        idle_for(75);

        // Random traffic: blk_valid toggling while busy, occasional abort.
        repeat (3000) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
            step();
        end
        idle_for(80);

        check("digest_count_R64", 32'(g_dut[0].got_digests),
              32'(g_dut[0].exp_digests));
        check("digest_count_R4", 32'(g_dut[1].got_digests),
              32'(g_dut[1].exp_digests));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha256_round_ctrl.md
SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

Interface
REQ-001 Parameter: ROUNDS, default 64, compression rounds per block; legal range 2..64.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: Reset  input  1  asynchronous, active-low reset.
REQ-004 Port: blk_valid  input  1  upstream 512-bit block present and stable until accepted.
REQ-005 Port: blk_first  input  1  block is first of message; sampled at acceptance.
REQ-006 Port: blk_last  input  1  block is last of message; sampled at acceptance.
REQ-007 Port: abort  input  1  synchronous abort of current message.
REQ-008 Port: blk_ready  output  1  controller can accept a block.
REQ-009 Port: w_init  output  1  load block into message-schedule register file.
REQ-010 Port: w_next  output  1  shift message schedule by one word.
REQ-011 Port: h_init  output  1  load SHA-256 initial hash values into H registers.
REQ-012 Port: ws_init  output  1  load working variables a..h from H.
REQ-013 Port: ws_update  output  1  perform one compression round.
REQ-014 Port: h_update  output  1  add working variables into H.
REQ-015 Port: round  output  6  current round index t, for K[t] lookup.
REQ-016 Port: busy  output  1  block in progress.
REQ-017 Port: digest_valid  output  1  one-cycle pulse: H holds final digest.

Function
REQ-018 States: IDLE, LOAD, PREP, ROUNDS, FINAL, DONE; one state per cycle except ROUNDS.
REQ-019 IDLE: blk_ready=1; blk_valid=1 is acceptance; blk_first, blk_last latched into first_q, last_q; next state LOAD.
REQ-020 blk_ready SHALL be 0 in every state except IDLE; blk_valid outside IDLE is ignored.
REQ-021 LOAD: w_init=1; h_init=first_q; next state PREP.
REQ-022 PREP: ws_init=1; next state ROUNDS with round counter cleared to 0.
REQ-023 ROUNDS: ws_update=1 and w_next=1 every cycle; round=counter; counter increments by 1; after cycle with counter=ROUNDS-1 next state FINAL.
REQ-024 round SHALL read 0 in every state except ROUNDS; counter never exceeds ROUNDS-1.
REQ-025 FINAL: h_update=1; next state DONE if last_q=1, else IDLE.
REQ-026 DONE: digest_valid=1 for exactly one cycle; next state IDLE.
REQ-027 busy=1 in LOAD, PREP, ROUNDS, FINAL, DONE; 0 in IDLE.
REQ-028 Latency: acceptance at cycle N gives w_init at N+1, ws_init at N+2, rounds N+3..N+2+ROUNDS, h_update at N+3+ROUNDS, digest_valid at N+4+ROUNDS (N+68 for default).
REQ-029 Throughput: non-last block back-to-back, next acceptance earliest at N+4+ROUNDS.
REQ-030 blk_first=blk_last=1 is a legal single-block message.
REQ-031 abort=1 in any non-IDLE state: next state IDLE, no h_update or digest_valid issued, first_q/last_q cleared; abort in IDLE has no effect and does not block acceptance of a simultaneous blk_valid.
REQ-032 abort has priority over all other transitions, including ROUNDS end and FINAL.
REQ-033 All strobe outputs SHALL be mutually consistent: at most one of w_init, ws_init, h_update, digest_valid high in any cycle; ws_update and w_next only together.
REQ-034 All outputs SHALL be decoded from registered state/counter only, glitch-free of inputs except none.

Reset
REQ-035 Reset=0 SHALL force IDLE, counter=0, first_q=0, last_q=0 immediately, independent of clk.
REQ-036 During and after reset until first acceptance: blk_ready=1 once Reset=1, all other outputs 0, round=0.
REQ-037 Reset asserted mid-block aborts the block with no further strobes after deassertion.

Verification
REQ-038 Single block: blk_valid=1, first=1, last=1 at cycle 0 -> h_init+w_init cycle 1, ws_init cycle 2, round 0..63 cycles 3..66, h_update 67, digest_valid 68, blk_ready 69.
REQ-039 Two-block message: second block held valid from cycle 1 -> accepted cycle 68, no digest_valid after first FINAL, h_init=0 on second LOAD, digest_valid at cycle 136.
REQ-040 abort asserted at round=30 -> next cycle IDLE, blk_ready=1, no h_update, no digest_valid.
REQ-041 Reset pulse during round 10 -> outputs 0 asynchronously, blk_ready=1 after release, fresh block completes normally.
REQ-042 ROUNDS=4 build: round sequences 0,1,2,3; digest_valid at N+8.
REQ-043 blk_valid toggled randomly while busy -> no extra acceptance, strobe counts per block exactly 1/1/ROUNDS/1.
